// File: rtl/psp_mem_arbiter.sv
// rtl/psp_mem_arbiter.sv - shares the PSP memory port between fetch and load/store requesters
module psp_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 1023
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_resp,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_resp,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_resp,
   output logic                busy,
   output logic                timeout_err,
   output logic                proto_err
);

   // Counter only has to reach TIMEOUT-1: the abort fires in the busy cycle
   // that would otherwise be the TIMEOUT-th cycle without a response.
   localparam int              TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0]   TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [3:0]      SLIM  = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t          state, state_nx;
   logic [3:0]      streak;
   logic [TW-1:0]   tcnt;
   logic            d_pend;
   logic            grant_d;
   logic            grant_i;
   logic            to_fire;
   logic            done;

   // Grant decision, timeout detection and next-state selection
   always_comb begin
      state_nx = state;
      d_pend   = d_read | d_write;
      grant_d  = (state == IDLE) && d_pend && (!i_read || (streak != SLIM));
      grant_i  = (state == IDLE) && i_read && !grant_d;
      to_fire  = (TIMEOUT != 0) && (state != IDLE) && !mem_resp && (tcnt == TLAST);
      done     = (state != IDLE) && (mem_resp || to_fire);
      case (state)
         IDLE: begin
            if (grant_d)
               state_nx = BUSY_D;
            else if (grant_i)
               state_nx = BUSY_I;
         end
         BUSY_I, BUSY_D: begin
            if (done)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Grant latches, strobes, starvation streak, timeout counter and sticky errors
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wmask   <= '0;
         streak      <= 4'd0;
         tcnt        <= '0;
         timeout_err <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         if (grant_d) begin
            // A write wins when both directions are asserted
            mem_addr  <= d_addr;
            mem_wdata <= d_write ? d_wdata : '0;
            mem_wmask <= d_write ? d_wmask : '0;
            mem_write <= d_write;
            mem_read  <= !d_write;
            if (d_read && d_write)
               proto_err <= 1'b1;
            if (i_read)
               streak <= (streak == SLIM) ? SLIM : streak + 4'd1;
            else
               streak <= 4'd0;
         end else if (grant_i) begin
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            streak    <= 4'd0;
         end else if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end
         if (state == IDLE)
            tcnt <= '0;
         else if (!mem_resp)
            tcnt <= tcnt + 1'b1;
         if (to_fire)
            timeout_err <= 1'b1;
      end
   end

   // Responses pass straight through to the owner; an abort returns zero data
   always_comb begin
      busy    = (state != IDLE);
      i_resp  = (state == BUSY_I) && (mem_resp || to_fire);
      d_resp  = (state == BUSY_D) && (mem_resp || to_fire);
      i_rdata = ((state == BUSY_I) && !to_fire) ? mem_rdata : '0;
      d_rdata = ((state == BUSY_D) && !to_fire) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_psp_mem_arbiter.sv
// tb/tb_psp_mem_arbiter.sv - directed self-checking bench for psp_mem_arbiter
module tb_psp_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_read;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_resp;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wmask;
   logic [31:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        busy;
   logic        timeout_err;
   logic        proto_err;

   int errors = 0;
   int checks = 0;

   psp_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .busy(busy), .timeout_err(timeout_err),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
      d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0; mem_resp = 1'b0;
      step; step;
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_mem_write", mem_write, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_timeout_err", timeout_err, 1'b0);
      chk1("rst_proto_err", proto_err, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_streak", 32'(dut.streak), 32'h0);
      reset_n = 1'b1;
      step;

      // fetch only, memory answers two cycles after the strobe rises
      i_read = 1'b1; i_addr = 32'h60;
      step;
      chk1("f_mem_read_c1", mem_read, 1'b1);
      chk1("f_mem_write_c1", mem_write, 1'b0);
      chk1("f_busy_c1", busy, 1'b1);
      chk32("f_mem_addr", mem_addr, 32'h60);
      chk32("f_mem_wmask", 32'(mem_wmask), 32'h0);
      chk1("f_i_resp_c1", i_resp, 1'b0);
      step;
      chk1("f_mem_read_c2", mem_read, 1'b1);
      step;
      mem_resp = 1'b1; mem_rdata = 32'h00000013;
      #1;
      chk1("f_i_resp_c3", i_resp, 1'b1);
      chk32("f_i_rdata_c3", i_rdata, 32'h00000013);
      chk1("f_d_resp_c3", d_resp, 1'b0);
      chk32("f_d_rdata_c3", d_rdata, 32'h0);
      step;
      i_read = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
      #1;
      chk1("f_mem_read_c4", mem_read, 1'b0);
      chk1("f_busy_c4", busy, 1'b0);

      // simultaneous fetch and store: store first, then fetch
      i_read = 1'b1; i_addr = 32'h64;
      d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wmask = 4'hF;
      step;
      chk1("s_mem_write", mem_write, 1'b1);
      chk1("s_mem_read", mem_read, 1'b0);
      chk32("s_mem_wmask", 32'(mem_wmask), 32'hF);
      chk32("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk32("s_mem_addr", mem_addr, 32'h100);
      mem_resp = 1'b1;
      #1;
      chk1("s_d_resp", d_resp, 1'b1);
      chk1("s_i_resp", i_resp, 1'b0);
      step;
      d_write = 1'b0; mem_resp = 1'b0;
      #1;
      chk1("s_gap_mem_write", mem_write, 1'b0);
      chk1("s_gap_mem_read", mem_read, 1'b0);
      chk1("s_gap_busy", busy, 1'b0);
      step;
      chk1("s_f_mem_read", mem_read, 1'b1);
      chk1("s_f_mem_write", mem_write, 1'b0);
      chk32("s_f_mem_addr", mem_addr, 32'h64);
      chk32("s_f_mem_wmask", 32'(mem_wmask), 32'h0);
      mem_resp = 1'b1; mem_rdata = 32'hAAAA5555;
      #1;
      chk1("s_f_i_resp", i_resp, 1'b1);
      chk32("s_f_i_rdata", i_rdata, 32'hAAAA5555);
      step;
      i_read = 1'b0; mem_resp = 1'b0;

      // starvation guard: four data grants, one fetch, then data again
      d_read = 1'b1; d_addr = 32'h200; d_wdata = '0; d_wmask = '0;
      i_read = 1'b1; i_addr = 32'h300;
      for (int g = 0; g < 6; g++) begin
         step;
         mem_resp = 1'b1; mem_rdata = 32'h1000 + 32'(g);
         #1;
         chk1("st_i_resp", i_resp, (g == 4));
         chk1("st_d_resp", d_resp, (g != 4));
         chk32("st_mem_addr", mem_addr, (g == 4) ? 32'h300 : 32'h200);
         if (g == 3) chk32("st_streak_full", 32'(dut.streak), 32'h4);
         if (g == 4) chk32("st_streak_clr", 32'(dut.streak), 32'h0);
         step;
         mem_resp = 1'b0;
         if (g == 4) i_read = 1'b0;
         #1;
         chk1("st_idle", busy, 1'b0);
      end
      d_read = 1'b0;
      step;

      // timeout: memory never answers the load
      d_read = 1'b1; d_addr = 32'h40; mem_rdata = 32'hFFFFFFFF;
      step;
      for (int c = 1; c < 8; c++) begin
         chk1("to_no_resp", d_resp, 1'b0);
         step;
      end
      chk1("to_d_resp", d_resp, 1'b1);
      chk32("to_d_rdata", d_rdata, 32'h0);
      chk1("to_err_before", timeout_err, 1'b0);
      chk1("to_strobe_last", mem_read, 1'b1);
      step;
      d_read = 1'b0;
      #1;
      chk1("to_err_set", timeout_err, 1'b1);
      chk1("to_strobe_drop", mem_read, 1'b0);
      chk1("to_busy_drop", busy, 1'b0);
      i_read = 1'b1; i_addr = 32'h80;
      step;
      mem_resp = 1'b1; mem_rdata = 32'h11223344;
      #1;
      chk1("to_f_i_resp", i_resp, 1'b1);
      chk32("to_f_i_rdata", i_rdata, 32'h11223344);
      step;
      i_read = 1'b0; mem_resp = 1'b0;
      #1;
      chk1("to_err_sticky", timeout_err, 1'b1);

      // reset in the middle of a fetch
      i_read = 1'b1; i_addr = 32'h90;
      step;
      chk1("rm_mem_read", mem_read, 1'b1);
      reset_n = 1'b0;
      step;
      chk1("rm_mem_read_rst", mem_read, 1'b0);
      chk1("rm_busy_rst", busy, 1'b0);
      chk1("rm_timeout_err_rst", timeout_err, 1'b0);
      chk1("rm_i_resp_rst", i_resp, 1'b0);
      chk32("rm_mem_addr_rst", mem_addr, 32'h0);
      reset_n = 1'b1; i_read = 1'b0; mem_resp = 1'b1; mem_rdata = 32'h55;
      #1;
      chk1("rm_stale_i_resp", i_resp, 1'b0);
      chk32("rm_stale_i_rdata", i_rdata, 32'h0);
      chk1("rm_stale_d_resp", d_resp, 1'b0);
      step;
      mem_resp = 1'b0;
      #1;
      chk1("rm_busy_after", busy, 1'b0);
      chk1("rm_mem_read_after", mem_read, 1'b0);

      // protocol error: both directions requested at grant
      d_read = 1'b1; d_write = 1'b1; d_addr = 32'h120; d_wdata = 32'h12345678; d_wmask = 4'h3;
      step;
      chk1("pe_mem_write", mem_write, 1'b1);
      chk1("pe_mem_read", mem_read, 1'b0);
      chk32("pe_mem_wmask", 32'(mem_wmask), 32'h3);
      chk32("pe_mem_wdata", mem_wdata, 32'h12345678);
      mem_resp = 1'b1;
      #1;
      chk1("pe_d_resp", d_resp, 1'b1);
      step;
      d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
      #1;
      chk1("pe_err_set", proto_err, 1'b1);
      step; step;
      chk1("pe_err_sticky", proto_err, 1'b1);
      reset_n = 1'b0;
      step;
      chk1("pe_err_reset", proto_err, 1'b0);
      reset_n = 1'b1;
      step;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
